// File: rtl/ext_sync_debounce.sv
// Per-channel synchroniser + debouncer with optional registered rise/fall pulses.
// Define EXT_SYNC_EDGE_EN to build the edge-pulse registers; otherwise rise/fall are tied to 0.
module ext_sync_debounce #(
   parameter int WIDTH     = 4,
   parameter int STAGES    = 2,
   parameter int DB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ext_signal,
   output logic [WIDTH-1:0] int_signal,
   output logic [WIDTH-1:0] busy,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("ext_sync_debounce: WIDTH must be 1..32");
   end
   if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("ext_sync_debounce: STAGES must be 2..4");
   end
   if (DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_bad_db
      $error("ext_sync_debounce: DB_CYCLES must be 1..65535");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [STAGES-1:0] sync_q;
      logic [CW-1:0]     cnt_q, cnt_d;
      logic              lvl_q, lvl_d;
      logic              s;

      // NOTE: state updates use <= so every flop samples pre-edge values of the others.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) sync_q <= '0;
         else     sync_q <= {sync_q[STAGES-2:0], ext_signal[i]};
      end

      assign s = sync_q[STAGES-1];

      // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
      always_comb begin
         cnt_d = cnt_q;
         lvl_d = lvl_q;
         if (s == lvl_q) begin
            cnt_d = '0;
         end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            lvl_d = s;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
         end
      end

      assign int_signal[i] = lvl_q;
      assign busy[i]       = |cnt_q;

`ifdef EXT_SYNC_EDGE_EN
      logic rise_q, fall_q;

      // Pulses are loaded at the same edge as the level, so they appear in the following cycle.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            rise_q <= lvl_d & ~lvl_q;
            fall_q <= ~lvl_d & lvl_q;
         end
      end

      assign rise[i] = rise_q;
      assign fall[i] = fall_q;
`else
      assign rise[i] = 1'b0;
      assign fall[i] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_ext_sync_debounce.sv
// Self-checking bench for ext_sync_debounce: vector table, corner sequences, and random
// stimulus against a window-based reference model (plus a DB_CYCLES=1 instance).
module tb_ext_sync_debounce;

   localparam int W    = 4;
   localparam int ST   = 2;
   localparam int DB   = 4;
   localparam int ST_B = 3;
`ifdef EXT_SYNC_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] ext;
   logic [W-1:0] int_s, busy, rise, fall;
   logic [0:0]   int_b, busy_b, rise_b, fall_b;

   always #5 clk = ~clk;

   ext_sync_debounce #(.WIDTH(W), .STAGES(ST), .DB_CYCLES(DB)) dut (
      .clk(clk), .rst(rst), .ext_signal(ext),
      .int_signal(int_s), .busy(busy), .rise(rise), .fall(fall)
   );

   ext_sync_debounce #(.WIDTH(1), .STAGES(ST_B), .DB_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .ext_signal(ext[0]),
      .int_signal(int_b), .busy(busy_b), .rise(rise_b), .fall(fall_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: an output flips once the last DB synced samples all disagree with it.
   logic [W-1:0] ext_hist[$];
   logic [W-1:0] s_hist[$];
   logic         b_hist[$];
   logic [W-1:0] m_int, m_busy, m_rise, m_fall, p_pulse;
   logic         mb_int;

   task automatic model_reset();
      ext_hist.delete();
      s_hist.delete();
      b_hist.delete();
      m_int = '0; m_busy = '0; m_rise = '0; m_fall = '0; p_pulse = '0;
      mb_int = 1'b0;
   endtask

   task automatic model_edge();
      logic [W-1:0] s_now;
      bit           loaded;
      s_now = (ext_hist.size() >= ST) ? ext_hist[ext_hist.size() - ST] : '0;
      ext_hist.push_back(ext);
      if (ext_hist.size() > ST) void'(ext_hist.pop_front());
      s_hist.push_back(s_now);
      if (s_hist.size() > DB) void'(s_hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
         loaded = (s_hist.size() == DB);
         for (int k = 0; k < s_hist.size(); k++)
            if (s_hist[k][i] == m_int[i]) loaded = 1'b0;
         m_busy[i] = !loaded && (s_now[i] != m_int[i]);
         if (loaded) begin
            if (s_now[i]) m_rise[i] = EDGE_EN;
            else          m_fall[i] = EDGE_EN;
            m_int[i] = s_now[i];
         end
      end
      mb_int = (b_hist.size() >= ST_B) ? b_hist[b_hist.size() - ST_B] : 1'b0;
      b_hist.push_back(ext[0]);
      if (b_hist.size() > ST_B) void'(b_hist.pop_front());
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check({tag, "/int"},   int_s, m_int);
      check({tag, "/busy"},  busy,  m_busy);
      check({tag, "/rise"},  rise,  m_rise);
      check({tag, "/fall"},  fall,  m_fall);
      check({tag, "/excl"},  rise & fall, '0);
      check({tag, "/consec"}, (rise | fall) & p_pulse, '0);
      check({tag, "/db1_int"},  int_b,  mb_int);
      check({tag, "/db1_busy"}, busy_b, 1'b0);
      p_pulse = rise | fall;
   endtask

   // Asserts rst between edges, checks the immediate clear, then releases after one edge.
   task automatic async_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check({tag, "/rst_int"},  int_s, '0);
      check({tag, "/rst_busy"}, busy,  '0);
      check({tag, "/rst_rise"}, rise,  '0);
      check({tag, "/rst_fall"}, fall,  '0);
      check({tag, "/rst_db1"},  int_b, 1'b0);
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   typedef struct {
      logic [W-1:0] ext;
      logic [W-1:0] e_int;
      logic [W-1:0] e_busy;
      logic [W-1:0] e_rise;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [W-1:0] or_rise, or_fall;
      int           nfall, lat, lat0, lat3, hold;

      tbl[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
      tbl[1] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
      tbl[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
      tbl[3] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
      tbl[4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
      tbl[5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
      tbl[6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
      tbl[7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};

      rst = 1'b0;
      ext = '0;
      model_reset();
      #1;
      async_reset("init");

      // Latency table: single channel held high from before edge 1.
      for (int r = 0; r < 8; r++) begin
         ext = tbl[r].ext;
         tick($sformatf("tbl%0d", r));
         check($sformatf("tbl%0d/int", r),  int_s, tbl[r].e_int);
         check($sformatf("tbl%0d/busy", r), busy,  tbl[r].e_busy);
         check($sformatf("tbl%0d/rise", r), rise,  tbl[r].e_rise & {W{EDGE_EN}});
         check($sformatf("tbl%0d/fall", r), fall,  '0);
      end

      // Three-cycle glitch on channel 1 must be rejected.
      or_rise = '0; or_fall = '0;
      for (int c = 0; c < 9; c++) begin
         ext = (c < 3) ? 4'b0011 : 4'b0001;
         tick($sformatf("glitch%0d", c));
         or_rise |= rise;
         or_fall |= fall;
      end
      check("glitch/int1",  int_s[1], 1'b0);
      check("glitch/busy1", busy[1],  1'b0);
      check("glitch/rise",  or_rise,  '0);
      check("glitch/fall",  or_fall,  '0);

      // All channels high, then all fall together.
      ext = 4'b1111;
      for (int c = 0; c < 8; c++) tick($sformatf("allhi%0d", c));
      check("allhi/int", int_s, 4'b1111);
      ext = 4'b0000;
      nfall = 0; lat = -1;
      for (int c = 1; c <= 9; c++) begin
         tick($sformatf("allfall%0d", c));
         if (fall == 4'b1111) nfall++;
         if (int_s == 4'b0000 && lat < 0) lat = c;
      end
      check("allfall/pulses",  nfall, EDGE_EN ? 1 : 0);
      check("allfall/latency", lat, 6);

      // Reset while channel 2 is mid-qualification (counter == 2).
      ext = 4'b0001;
      for (int c = 0; c < 7; c++) tick($sformatf("pre%0d", c));
      ext = 4'b0101;
      for (int c = 0; c < 4; c++) tick($sformatf("mid%0d", c));
      check("mid/busy2", busy[2], 1'b1);
      async_reset("midq");
      lat = -1;
      for (int c = 1; c <= 12; c++) begin
         tick($sformatf("requal%0d", c));
         if (int_s[2] && lat < 0) lat = c;
      end
      check("requal/latency2", lat, 6);

      // Staggered channels 0 and 3.
      ext = 4'b0000;
      for (int c = 0; c < 8; c++) tick($sformatf("clr%0d", c));
      lat0 = -1; lat3 = -1;
      ext = 4'b0001;
      for (int c = 1; c <= 12; c++) begin
         if (c == 3) ext = 4'b1001;
         tick($sformatf("stag%0d", c));
         if (int_s[0] && lat0 < 0) lat0 = c;
         if (int_s[3] && lat3 < 0) lat3 = c - 2;
      end
      check("stag/latency0", lat0, 6);
      check("stag/latency3", lat3, 6);

      // Random bursts with occasional mid-stream resets.
      hold = 0;
      for (int c = 0; c < 2000; c++) begin
         if (hold == 0) begin
            ext  = ($urandom_range(0, 1) == 0) ? ext ^ (4'b0001 << $urandom_range(0, 3))
                                               : W'($urandom);
            hold = $urandom_range(1, 8);
         end
         hold--;
         if ($urandom_range(0, 299) == 0) async_reset($sformatf("rnd_rst%0d", c));
         tick($sformatf("rnd%0d", c));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ext_sync_debounce.md
EXT_SYNC_DEBOUNCE -- requirements
Module: ext_sync_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent input channels, 1..32.
REQ-002 SHALL have parameter STAGES, default 2: synchroniser flop depth per channel, 2..4.
REQ-003 SHALL have parameter DB_CYCLES, default 16: consecutive stable cycles required before an output change, 1..65535.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ext_signal  input  WIDTH  asynchronous external inputs, one bit per channel.
REQ-007 SHALL have port int_signal  output  WIDTH  synchronised, debounced level per channel.
REQ-008 SHALL have port busy  output  WIDTH  per channel: 1 while a pending change is being qualified.
REQ-009 SHALL have port rise  output  WIDTH  per channel: 1-cycle pulse on int_signal 0->1.
REQ-010 SHALL have port fall  output  WIDTH  per channel: 1-cycle pulse on int_signal 1->0.

Function
REQ-011 Channels SHALL be fully independent; no state is shared between channel bits.
REQ-012 Each channel SHALL pass ext_signal[i] through a STAGES-deep flop chain; the last stage is the synced value s[i].
REQ-013 Each channel SHALL have a counter of width clog2(DB_CYCLES+1) that never exceeds DB_CYCLES.
REQ-014 When s[i] equals int_signal[i] at a clock edge, the counter SHALL clear to 0.
REQ-015 When s[i] differs from int_signal[i] and counter+1 < DB_CYCLES, the counter SHALL increment.
REQ-016 When s[i] differs from int_signal[i] and counter+1 = DB_CYCLES, int_signal[i] SHALL load s[i] and the counter SHALL clear, at the same edge.
REQ-017 Latency: if ext_signal[i] changes before edge 1 and is held, int_signal[i] SHALL change at edge STAGES+DB_CYCLES, never earlier.
REQ-018 A glitch on s[i] that lasts fewer than DB_CYCLES cycles SHALL leave int_signal[i] unchanged and return the counter to 0.
REQ-019 busy[i] SHALL be combinationally equal to (counter[i] != 0).
REQ-020 rise[i] SHALL be registered and SHALL be high for exactly the one cycle following the edge at which int_signal[i] goes 0->1; fall[i] SHALL behave the same for 1->0.
REQ-021 rise[i] and fall[i] SHALL never be high together, and SHALL never be high on consecutive cycles for the same channel.
REQ-022 With DB_CYCLES=1, int_signal[i] SHALL follow s[i] with one cycle of delay, and busy SHALL remain 0.
REQ-023 Parameter values outside the ranges in REQ-001..003 SHALL cause an elaboration error.

Reset
REQ-024 rst high SHALL immediately clear all synchroniser flops, counters, int_signal, busy, rise and fall to 0, independent of clk.
REQ-025 Reset asserted mid-qualification SHALL discard the pending change; after release, qualification SHALL restart from counter 0.
REQ-026 No rise or fall pulse SHALL be generated by reset assertion or release.

Configuration
REQ-027 Macro EXT_SYNC_EDGE_EN SHALL control edge-pulse generation.
REQ-028 With EXT_SYNC_EDGE_EN defined, rise and fall SHALL behave per REQ-020..021.
REQ-029 Without EXT_SYNC_EDGE_EN, the rise and fall ports SHALL remain present and SHALL be driven constant 0, and no edge registers SHALL be instantiated.

Verification (WIDTH=4, STAGES=2, DB_CYCLES=4, EXT_SYNC_EDGE_EN defined unless noted)
REQ-030 Hold ext_signal=4'b0001 from before edge 1 -> int_signal=4'b0001 after edge 6 and not before; rise=4'b0001 for exactly one cycle; busy[0] is high after edges 3..5.
REQ-031 Drive ext_signal[1]=1 for 3 cycles, then 0 -> int_signal[1] stays 0, busy[1] returns to 0, rise and fall stay 0.
REQ-032 Start with int_signal=4'b1111, drive ext_signal=4'b0000 and hold -> fall=4'b1111 for one cycle, then int_signal=4'b0000.
REQ-033 Assert rst asynchronously while counter[2]=2 -> all outputs 0 immediately; after release, int_signal[2] changes only after a full 2+4 edges.
REQ-034 Drive ch0 high and ch3 low->high at staggered cycles -> each channel meets latency 6 independently, and the pulses do not interact.
REQ-035 Rebuild without EXT_SYNC_EDGE_EN and repeat REQ-030 -> int_signal timing is identical, and rise and fall stay 0 throughout.
